// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: types and constants for the arbitrated adder front end.
//   state_e     - result register state (EMPTY / FULL)
//   NUM_REQ     - default number of requesters
//   COUNT_WIDTH - width of the accepted-operation counter
package adder_arb_pkg;

  localparam int NUM_REQ     = 4;
  localparam int COUNT_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : adder_arb_pkg

// File: rtl/adder_pkg.sv
// adder_pkg: shared datapath parameters for the adder family.
//   WIDTH - default operand / sum width in bits.
package adder_pkg;

  localparam int WIDTH = 32;

endpackage : adder_pkg

// File: rtl/adder.sv
// adder: unsigned p_width-bit adder with carry out, purely combinational.
//   i_a, i_b - operands
//   o_sum    - low p_width bits of i_a + i_b
//   o_co     - carry out of i_a + i_b
module adder #(
  parameter int p_width = adder_pkg::WIDTH
) (
  input  logic [p_width-1:0] i_a,
  input  logic [p_width-1:0] i_b,
  output logic [p_width-1:0] o_sum,
  output logic               o_co
);

  // Zero-extend both operands so the carry lands in the top bit.
  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule : adder

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_req          - request vector
//   i_en           - arbitration enable; no grant is issued while low
//   o_grant        - one-hot grant (all zero when disabled or idle)
//   o_grant_id     - index of the granted requester
// The pointer advances to one past the winner whenever a grant is issued,
// which bounds the wait of a continuously requesting input to p_num_req grants.
module rr_arbiter #(
  parameter int p_num_req  = 4,
  parameter int p_id_width = $clog2(p_num_req)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [p_num_req-1:0]  i_req,
  input  logic                  i_en,
  output logic [p_num_req-1:0]  o_grant,
  output logic [p_id_width-1:0] o_grant_id
);

  logic [p_id_width-1:0] ptr_q;
  logic [p_id_width-1:0] ptr_d;
  logic [p_num_req-1:0]  grant_s;
  logic [p_id_width-1:0] grant_id_s;
  logic                  found_s;
  // One spare bit so ptr + offset cannot overflow before the wrap subtract.
  logic [p_id_width:0]   pos_s;
  logic [p_id_width-1:0] idx_s;

  // Search upward from the pointer with wrap-around for the first request.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    pos_s      = '0;
    idx_s      = '0;
    for (int i = 0; i < p_num_req; i++) begin
      pos_s = {1'b0, ptr_q} + (p_id_width+1)'(i);
      if (pos_s >= (p_id_width+1)'(p_num_req)) begin
        pos_s = pos_s - (p_id_width+1)'(p_num_req);
      end else begin
        pos_s = pos_s;
      end
      idx_s = pos_s[p_id_width-1:0];
      if (!found_s && i_en && i_req[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_id_s     = idx_s;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer: one past the winner, modulo p_num_req; hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (found_s) begin
      if (grant_id_s == p_id_width'(p_num_req - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_id_s + p_id_width'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_grant    = grant_s;
  assign o_grant_id = grant_id_s;

endmodule : rr_arbiter

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder among p_num_req requesters through a
// round-robin grant and a single-entry result register.
//   i_clk, i_rst_n       - clock, asynchronous active-low reset
//   i_req_valid/a/b      - per-requester operation and operands
//   o_req_ready          - one-hot grant (acceptance = valid & ready)
//   o_rsp_valid/id/sum/co- registered result, held until i_rsp_ready
//   i_rsp_ready          - consumer takes the result this cycle
//   o_op_count           - wrapping count of accepted operations
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int p_width    = adder_pkg::WIDTH,
  parameter int p_num_req  = NUM_REQ,
  parameter int p_id_width = $clog2(p_num_req)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [p_num_req-1:0]              i_req_valid,
  input  logic [p_num_req-1:0][p_width-1:0] i_req_a,
  input  logic [p_num_req-1:0][p_width-1:0] i_req_b,
  output logic [p_num_req-1:0]              o_req_ready,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [p_id_width-1:0]             o_rsp_id,
  output logic [p_width-1:0]                o_rsp_sum,
  output logic                              o_rsp_co,
  output logic [COUNT_WIDTH-1:0]            o_op_count
);

  state_e                 state_q, state_d;
  logic [p_id_width-1:0]  id_q, id_d;
  logic [p_width-1:0]     sum_q, sum_d;
  logic                   co_q, co_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                   slot_avail_s;
  logic                   arb_en_s;
  logic [p_num_req-1:0]   grant_s;
  logic [p_id_width-1:0]  grant_id_s;
  logic                   accept_s;
  logic [p_width-1:0]     add_a_s;
  logic [p_width-1:0]     add_b_s;
  logic [p_width-1:0]     add_sum_s;
  logic                   add_co_s;

  // Slot is free when empty, or when full and being drained this cycle.
  // Reset gates the enable so no grant is visible while i_rst_n is low.
  always_comb begin
    slot_avail_s = 1'b0;
    if (state_q == EMPTY) begin
      slot_avail_s = 1'b1;
    end else begin
      slot_avail_s = i_rsp_ready;
    end
    arb_en_s = slot_avail_s & i_rst_n;
  end

  rr_arbiter #(
    .p_num_req  (p_num_req),
    .p_id_width (p_id_width)
  ) u_rr_arbiter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req_valid),
    .i_en       (arb_en_s),
    .o_grant    (grant_s),
    .o_grant_id (grant_id_s)
  );

  assign accept_s = |grant_s;

  // Operand mux steered by the granted index.
  always_comb begin
    add_a_s = i_req_a[grant_id_s];
    add_b_s = i_req_b[grant_id_s];
  end

  adder #(
    .p_width (p_width)
  ) u_adder (
    .i_a   (add_a_s),
    .i_b   (add_b_s),
    .o_sum (add_sum_s),
    .o_co  (add_co_s)
  );

  // Result-register state machine: acceptance wins over a plain drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (accept_s) begin
          state_d = FULL;
        end else if (i_rsp_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Result payload and operation counter load only on acceptance.
  always_comb begin
    id_d  = id_q;
    sum_d = sum_q;
    co_d  = co_q;
    cnt_d = cnt_q;
    if (accept_s) begin
      id_d  = grant_id_s;
      sum_d = add_sum_s;
      co_d  = add_co_s;
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      id_q    <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_req_ready = grant_s;
  assign o_rsp_valid = (state_q == FULL);
  assign o_rsp_id    = id_q;
  assign o_rsp_sum   = sum_q;
  assign o_rsp_co    = co_q;
  assign o_op_count  = cnt_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed, table-driven bench for adder_arbiter
// (4 requesters, 32-bit operands) plus hand-written reset, round-robin
// and counter-wrap sequences.
module tb_adder_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req_valid;
  logic [3:0][31:0]  req_a;
  logic [3:0][31:0]  req_b;
  logic [3:0]        req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_sum;
  logic              rsp_co;
  logic [15:0]       op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_co    (rsp_co),
    .o_op_count  (op_count)
  );

  localparam logic [127:0] A_STD = {32'd40, 32'd30, 32'd20, 32'd10};
  localparam logic [127:0] B_STD = {32'd4, 32'd3, 32'd2, 32'd1};

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] a;
    logic [127:0] b;
    logic         rr;
    logic [3:0]   e_ready;
    logic         e_rv;
    logic [1:0]   e_id;
    logic [31:0]  e_sum;
    logic         e_co;
    logic [15:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [3:0] valid, input logic [127:0] a,
                                  input logic [127:0] b, input logic rr,
                                  input logic [3:0] e_ready, input logic e_rv,
                                  input logic [1:0] e_id, input logic [31:0] e_sum,
                                  input logic e_co, input logic [15:0] e_cnt);
    vec_t v;
    v.valid = valid; v.a = a; v.b = b; v.rr = rr;
    v.e_ready = e_ready; v.e_rv = e_rv; v.e_id = e_id;
    v.e_sum = e_sum; v.e_co = e_co; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk_rsp(input string tag, input logic rv, input logic [1:0] id,
                         input logic [31:0] sum, input logic co, input logic [15:0] cnt);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(rv));
    chk({tag, ".rsp_id"},    64'(rsp_id),    64'(id));
    chk({tag, ".rsp_sum"},   64'(rsp_sum),   64'(sum));
    chk({tag, ".rsp_co"},    64'(rsp_co),    64'(co));
    chk({tag, ".op_count"},  64'(op_count),  64'(cnt));
  endtask

  initial begin
    // Expected values below are hand-computed; pointer noted per row.
    //      valid    a                           b                           rr    ready    rv    id     sum            co    cnt
    add_vec(4'b0001, {96'd0, 32'd5},            {96'd0, 32'd7},            1'b1, 4'b0001, 1'b1, 2'd0, 32'd12,        1'b0, 16'd1);  // ptr->1
    add_vec(4'b0010, {64'd0, 32'hFFFFFFFF, 32'd0}, {64'd0, 32'd1, 32'd0}, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd0,         1'b1, 16'd2);  // ptr->2
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b1, 4'b0100, 1'b1, 2'd2, 32'd33,        1'b0, 16'd3);  // ptr->3
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b1, 4'b1000, 1'b1, 2'd3, 32'd44,        1'b0, 16'd4);  // ptr->0
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b1, 4'b0001, 1'b1, 2'd0, 32'd11,        1'b0, 16'd5);  // ptr->1
    add_vec(4'b0000, A_STD,                     B_STD,                     1'b1, 4'b0000, 1'b0, 2'd0, 32'd11,        1'b0, 16'd5);  // drain
    add_vec(4'b0000, A_STD,                     B_STD,                     1'b0, 4'b0000, 1'b0, 2'd0, 32'd11,        1'b0, 16'd5);  // idle
    add_vec(4'b0101, A_STD,                     B_STD,                     1'b0, 4'b0100, 1'b1, 2'd2, 32'd33,        1'b0, 16'd6);  // ptr->3
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b0, 4'b0000, 1'b1, 2'd2, 32'd33,        1'b0, 16'd6);  // stall
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b0, 4'b0000, 1'b1, 2'd2, 32'd33,        1'b0, 16'd6);  // stall
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b0, 4'b0000, 1'b1, 2'd2, 32'd33,        1'b0, 16'd6);  // stall
    add_vec(4'b1111, A_STD,                     B_STD,                     1'b1, 4'b1000, 1'b1, 2'd3, 32'd44,        1'b0, 16'd7);  // drain+refill, ptr->0
    add_vec(4'b0110, A_STD,                     B_STD,                     1'b1, 4'b0010, 1'b1, 2'd1, 32'd22,        1'b0, 16'd8);  // ptr->2
    add_vec(4'b0011, A_STD,                     B_STD,                     1'b1, 4'b0001, 1'b1, 2'd0, 32'd11,        1'b0, 16'd9);  // wrap, ptr->1
    add_vec(4'b1000, {32'hFFFFFFFF, A_STD[95:0]}, {32'hFFFFFFFF, B_STD[95:0]}, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hFFFFFFFE, 1'b1, 16'd10); // ptr->0
    add_vec(4'b0000, A_STD,                     B_STD,                     1'b1, 4'b0000, 1'b0, 2'd3, 32'hFFFFFFFE,  1'b1, 16'd10); // drain

    // Reset with requests pending: nothing granted, everything zero.
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = A_STD;
    req_b     = B_STD;
    rsp_ready = 1'b1;
    #2;
    chk("reset.req_ready", 64'(req_ready), 64'd0);
    chk_rsp("reset", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_hold.req_ready", 64'(req_ready), 64'd0);
    chk_rsp("reset_hold", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
    rst_n = 1'b1;

    // Table: drive just after a rising edge, check grant mid-cycle,
    // check registered result just after the next rising edge.
    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].valid;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      rsp_ready = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      chk_rsp($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_id, vecs[i].e_sum,
              vecs[i].e_co, vecs[i].e_cnt);
    end

    // Fill the result register with the consumer stalled, then reset mid-cycle.
    req_valid = 4'b1111;
    req_a     = A_STD;
    req_b     = B_STD;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_rsp("pre_async", 1'b1, 2'd0, 32'd11, 1'b0, 16'd11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async.req_ready", 64'(req_ready), 64'd0);
    chk_rsp("async", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    chk_rsp("async_hold", 1'b0, 2'd0, 32'd0, 1'b0, 16'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;

    // All four valid continuously: grants 0,1,2,3,0, one result per cycle.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d.req_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      @(posedge clk);
      #1;
      chk_rsp($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 32'(11 * ((k % 4) + 1)), 1'b0, 16'(k + 1));
    end

    // Counter wrap: clean reset, 65535 accepted operations, then one more.
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap.op_count_ffff", 64'(op_count), 64'hFFFF);
    @(posedge clk);
    #1;
    chk_rsp("wrap", 1'b1, 2'd0, 32'd11, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_adder_arbiter
